// File: rtl/bcd_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_scan_driver : 8-bit binary to 3-digit BCD (double dabble) feeding a
//                   multiplexed 4-digit active-low seven-segment display.
// Revision 1.0
// ---------------------------------------------------------------------------
module bcd_scan_driver #(
   parameter int REFRESH_DIV = 100_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] din,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic [3:0] anode,
   output logic [6:0] seg
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [11:0]      bcd_q, bcd_d, adj;
   logic [2:0]       cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic [7:0]       pend_val_q, pend_val_d;
   logic [3:0]       hund_q, hund_d, ten_q, ten_d, ones_q, ones_d;
   logic             done_q, done_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       slot_q, slot_d;
   logic [3:0]       anode_q, anode_d, nib;
   logic [6:0]       seg_q, seg_d;
   logic             blank;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      hund_d     = hund_q;
      ten_d      = ten_q;
      ones_d     = ones_q;
      done_d     = 1'b0;
      adj        = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = SHIFT;
               shift_d = din;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            bcd_d   = {adj[10:0], shift_q[7]};
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = DONE;
            if (load) begin
               pend_d     = 1'b1;
               pend_val_d = din;
            end
         end
         DONE: begin
            hund_d = bcd_q[11:8];
            ten_d  = bcd_q[7:4];
            ones_d = bcd_q[3:0];
            done_d = 1'b1;
            pend_d = 1'b0;
            // A load arriving now is newer than anything pending, so it wins.
            if (load || pend_q) begin
               state_d = SHIFT;
               shift_d = load ? din : pend_val_q;
               bcd_d   = '0;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan outputs are built from next-state slot/digits so they land on the same edge.
   always_comb begin
      div_d  = div_q + DIV_W'(1);
      slot_d = slot_q;
      if (div_q == DIV_LAST) begin
         div_d  = '0;
         slot_d = slot_q + 2'd1;
      end
      nib     = ones_d;
      blank   = 1'b0;
      anode_d = 4'b1110;
      case (slot_d)
         2'd0: begin
            nib     = ones_d;
            anode_d = 4'b1110;
         end
         2'd1: begin
            nib     = ten_d;
            blank   = (hund_d == 4'd0) && (ten_d == 4'd0);
            anode_d = 4'b1101;
         end
         2'd2: begin
            nib     = hund_d;
            blank   = (hund_d == 4'd0);
            anode_d = 4'b1011;
         end
         default: begin
            blank   = 1'b1;
            anode_d = 4'b1111;
         end
      endcase
      seg_d = blank ? 7'b1111111 : seg_of(nib);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         hund_q     <= '0;
         ten_q      <= '0;
         ones_q     <= '0;
         done_q     <= 1'b0;
         div_q      <= '0;
         slot_q     <= '0;
         anode_q    <= 4'b1111;
         seg_q      <= 7'b1111111;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         hund_q     <= hund_d;
         ten_q      <= ten_d;
         ones_q     <= ones_d;
         done_q     <= done_d;
         div_q      <= div_d;
         slot_q     <= slot_d;
         anode_q    <= anode_d;
         seg_q      <= seg_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign anode = anode_q;
   assign seg   = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_scan_driver : scoreboard bench with a transaction-level model of
//                      conversions, pending loads and the display scan.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_bcd_scan_driver;

   localparam int DIV = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       load = 1'b0;
   logic [7:0] din = 8'd0;
   logic       busy, done;
   logic [3:0] anode;
   logic [6:0] seg;

   bcd_scan_driver #(.REFRESH_DIV(DIV)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .din   (din),
      .load  (load),
      .busy  (busy),
      .done  (done),
      .anode (anode),
      .seg   (seg)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int edge_n;
      int val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Model state owned by the stimulus process: edges since reset release,
   // the conversion in flight and the pending request.
   int   k = 0;
   bit   conv_on = 1'b0;
   int   conv_end = 0;
   int   conv_val = 0;
   bit   pend_on = 1'b0;
   int   pend_val = 0;

   function automatic logic [6:0] seg_pat(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int slot);
      case (slot)
         0: return seg_pat(v % 10);
         1: return (v < 10) ? 7'b1111111 : seg_pat((v / 10) % 10);
         2: return (v < 100) ? 7'b1111111 : seg_pat(v / 100);
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [3:0] exp_anode(input int slot);
      case (slot)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         default: return 4'b1111;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_conv(input int v);
      conv_on  = 1'b1;
      conv_val = v;
      conv_end = k + 9;
   endtask

   task automatic model_edge(input bit ld, input int d);
      k++;
      if (conv_on && k == conv_end) begin
         sb.push_back('{k, conv_val});
         if (ld) start_conv(d);
         else if (pend_on) start_conv(pend_val);
         else conv_on = 1'b0;
         pend_on = 1'b0;
      end else if (conv_on) begin
         if (ld) begin
            pend_on  = 1'b1;
            pend_val = d;
         end
      end else if (ld) begin
         start_conv(d);
      end
   endtask

   task automatic step(input bit ld, input int d);
      @(negedge CLK);
      load = ld;
      din  = d[7:0];
      @(posedge CLK);
      model_edge(ld, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0);
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RST  = 1'b1;
      load = 1'b0;
      @(posedge CLK);
      model_edge(1'b0, 0);
   endtask

   task automatic model_reset();
      k       = 0;
      conv_on = 1'b0;
      pend_on = 1'b0;
   endtask

   // Monitor: pops the scoreboard on done and checks the scan every cycle.
   initial begin
      int  mon_disp;
      int  slot;
      bit  exp_done;
      mon_disp = 0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            mon_disp = 0;
            sb.delete();
            chk("rst_anode", int'(anode), 'hf);
            chk("rst_seg", int'(seg), 'h7f);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
         end else begin
            exp_done = (sb.size() > 0) && (sb[0].edge_n == k);
            if (done) begin
               if (sb.size() == 0) begin
                  chk("done_unexpected", 1, 0);
               end else begin
                  chk("done_edge", k, sb[0].edge_n);
                  mon_disp = sb[0].val;
                  void'(sb.pop_front());
               end
            end else if (exp_done) begin
               chk("done_missing", 0, 1);
               mon_disp = sb[0].val;
               void'(sb.pop_front());
            end
            chk("busy", int'(busy), int'(conv_on));
            slot = (k / DIV) % 4;
            chk("anode", int'(anode), int'(exp_anode(slot)));
            chk("seg", int'(seg), int'(exp_seg(mon_disp, slot)));
         end
      end
   end

   initial begin
      repeat (3) @(negedge CLK);
      release_reset();
      idle(17);

      // Full-scale value, then a single digit with blanked leading zeros.
      step(1'b1, 255);
      idle(20);
      step(1'b1, 7);
      idle(20);

      // Two loads while busy: only the later one is converted afterwards.
      step(1'b1, 100);
      idle(2);
      step(1'b1, 42);
      idle(2);
      step(1'b1, 9);
      idle(25);

      // Load in the same cycle that done is high.
      step(1'b1, 123);
      idle(9);
      step(1'b1, 58);
      idle(20);

      // Reset in the middle of a conversion.
      step(1'b1, 200);
      idle(4);
      @(negedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
      #1;
      chk("async_rst_anode", int'(anode), 'hf);
      chk("async_rst_seg", int'(seg), 'h7f);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      repeat (2) @(negedge CLK);
      release_reset();
      idle(20);

      // Randomised loads, some landing while busy.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 5) == 0), int'($urandom_range(0, 255)));
      end
      idle(30);

      @(negedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_scan_driver.md
BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100_000, CLK cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= 2.
REQ-002 SHALL have port CLK  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port din  input  8  unsigned binary value from the FIFO dout.
REQ-005 SHALL have port load  input  1  one-cycle request to convert din.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when new digits are latched.
REQ-008 SHALL have port anode  output  4  active-low digit enables; anode[0] = ones.
REQ-009 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-010 SHALL implement a conversion FSM with states IDLE, SHIFT and DONE.
REQ-011 SHALL, in IDLE with load=1, capture din into a shift register, clear the 12-bit BCD scratch, clear the bit counter, and enter SHIFT.
REQ-012 SHALL, in each SHIFT cycle, add 3 to every scratch nibble >= 5 and then shift {scratch, shift register} left by one bit (double dabble).
REQ-013 SHALL leave SHIFT for DONE after exactly 8 SHIFT cycles.
REQ-014 SHALL, in DONE, copy the scratch into display registers hund/ten/ones, pulse done for one cycle, and return to IDLE.
REQ-015 SHALL produce a fixed latency: load sampled at edge N gives done=1 and updated digits in the cycle after edge N+9.
REQ-016 SHALL hold busy=1 in SHIFT and DONE and busy=0 in IDLE.
REQ-017 SHALL capture din into a pending register and set a pending flag when load=1 while busy=1; a later load overwrites the pending value.
REQ-018 SHALL, on leaving DONE with the pending flag set, clear the flag and start a new conversion of the pending value from the next cycle, with no IDLE cycle.
REQ-019 SHALL ensure display registers change only in DONE, so a partial conversion is never displayed.
REQ-020 SHALL run a free-running divider counting 0..REFRESH_DIV-1; at terminal count the 2-bit slot index increments and wraps 3 -> 0.
REQ-021 SHALL drive anode from the slot index: slot 0 = 4'b1110 (ones), slot 1 = 4'b1101 (tens), slot 2 = 4'b1011 (hundreds), slot 3 = 4'b1111 (all off).
REQ-022 SHALL decode digits 0-9 to standard active-low patterns, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
REQ-023 SHALL drive seg = 7'b1111111 for blanked digits, in slot 3, and for any nibble > 9.
REQ-024 SHALL blank leading zeros: hundreds when hund=0; tens when hund=0 and ten=0; ones is never blanked.
REQ-025 SHALL register anode and seg so that both change on the same edge, with no glitch between slots.
REQ-026 SHALL run scan and conversion independently; a digit update takes effect in the current slot on the cycle after DONE.

Reset
REQ-027 SHALL, while RST=0, force FSM=IDLE, busy=0, done=0, pending=0, hund/ten/ones=0, divider=0, slot=0, anode=4'b1111, seg=7'b1111111.
REQ-028 SHALL abandon any conversion in progress on RST assertion; no done pulse follows and display registers read 0.
REQ-029 SHALL, on the first edge after RST release, show slot 0 as anode=4'b1110, seg=7'b1000000 ("0").

Verification (REFRESH_DIV=4)
REQ-030 SHALL cover: load with din=8'd255 -> busy for 9 cycles, done pulse, digits 2/5/5, slots 0/1/2 show 5, 5, 2.
REQ-031 SHALL cover: load with din=8'd7 -> ones slot shows 7'b1111000, tens and hundreds slots show seg=7'b1111111.
REQ-032 SHALL cover: load din=8'd100, then load din=8'd42 and din=8'd9 during busy -> digits 100, then exactly one extra conversion giving 009 (9 displayed alone), two done pulses in total.
REQ-033 SHALL cover: RST asserted at SHIFT cycle 4 of din=8'd200 -> immediate reset values, no done pulse, display shows "0".
REQ-034 SHALL cover: scan over 16 cycles -> anode sequence 1110, 1101, 1011, 1111, each held 4 cycles, then wraps to 1110.
REQ-035 SHALL cover: load pulsed in the same cycle that done is high -> treated as pending, conversion restarts on the next cycle, second done pulse 9 cycles later.
